// File: rtl/snowball_memrsp_pkg.sv
`timescale 1ns/1ps
// Shared types, defaults and the pair-word rule for the snowball memory-port responder.
package snowball_memrsp_pkg;

    localparam int SNOWBALL_ADDR_W = 10;
    localparam int SNOWBALL_RD_LAT = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACK      = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_W0    = 3'd3,
        ST_RD_W1    = 3'd4,
        ST_DROP     = 3'd5,
        ST_DMA_GO   = 3'd6,
        ST_DMA_DONE = 3'd7
    } state_e;

    typedef enum logic {
        WIN_CACHE = 1'b0,
        WIN_DMA   = 1'b1
    } winner_e;

    // The second beat of a burst is the other word of the aligned pair.
    function automatic logic [31:0] pair_word(input logic [31:0] a);
        return {a[31:1], ~a[0]};
    endfunction

endpackage

// File: rtl/snowball_memrsp_store.sv
`timescale 1ns/1ps
// Word store: one write port, one read port with a registered (1-cycle) read.
// Plain array with no reset so it maps onto block RAM.
module snowball_memrsp_store
    import snowball_memrsp_pkg::*;
#(
    parameter int ADDR_W = SNOWBALL_ADDR_W
) (
    input  logic              CPU_CLK,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge CPU_CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/snowball_mem_responder.sv
`timescale 1ns/1ps
// Memory-side responder: cache writes, fixed-latency two-word read bursts, DMA port arbitration.
// Optional SNOWBALL_MEMRSP_STATS_EN adds stat_rd/stat_wr/stat_dma request counters.
module snowball_mem_responder
    import snowball_memrsp_pkg::*;
#(
    parameter int ADDR_W = SNOWBALL_ADDR_W,
    parameter int RD_LAT = SNOWBALL_RD_LAT
) (
    input  logic        CPU_CLK,
    input  logic        RST,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic        mem_do_act,
    input  logic [31:0] mem_dataintomem,
    output logic        mem_ack,
    output logic [31:0] mem_datafrommem,
    output logic        dma_mcu_access,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata
`ifdef SNOWBALL_MEMRSP_STATS_EN
    ,
    output logic [31:0] stat_rd,
    output logic [31:0] stat_wr,
    output logic [31:0] stat_dma
`endif
);

    // RD_WAIT spans cycles T+1..T+RD_LAT-1; the pair is issued in its last two cycles (RD_LAT >= 3).
    localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_ISSUE = CNT_W'(RD_LAT - 3);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RD_LAT - 2);

    state_e            state_q, state_d;
    winner_e           last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dma_ph_q, dma_ph_d;
    logic              rd_vld_p0, rd_vld_p1_q;

    logic              mem_ack_q, mem_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              access_q, access_d;
    logic [31:0]       mem_rdata_q;
    logic [31:0]       dma_rdata_q;
    logic              dma_rd_load;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [31:0]       ram_wdata, ram_rdata;

    logic              cache_win, dma_win;
    logic [31:0]       pair_full;
    logic              unused_addr_hi;

    assign cache_win = mem_do_act && (!dma_req || (last_q == WIN_DMA));
    assign dma_win   = dma_req && (!mem_do_act || (last_q == WIN_CACHE));
    assign pair_full = pair_word({{(32-ADDR_W){1'b0}}, addr_q});
    assign unused_addr_hi = ^{mem_addr[31:ADDR_W], dma_addr[31:ADDR_W], pair_full[31:ADDR_W]};

    always_ff @(posedge CPU_CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cache_win) begin
                    state_d = ST_ACK;
                end else if (dma_win) begin
                    state_d = ST_DMA_GO;
                end
            end
            ST_ACK:      state_d = mem_we ? ST_DROP : ST_RD_WAIT;
            ST_RD_WAIT:  if (cnt_q == CNT_LAST) state_d = ST_RD_W0;
            ST_RD_W0:    state_d = ST_RD_W1;
            ST_RD_W1:    state_d = ST_DROP;
            // The initiator still holds its request for a couple of cycles after the ack.
            ST_DROP:     if (!mem_do_act) state_d = ST_IDLE;
            ST_DMA_GO:   if (dma_ph_q) state_d = ST_DMA_DONE;
            ST_DMA_DONE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        access_d    = access_q;
        last_d      = last_q;
        addr_d      = addr_q;
        cnt_d       = '0;
        dma_ph_d    = 1'b0;
        dma_rd_load = 1'b0;
        rd_vld_p0   = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_waddr   = mem_addr[ADDR_W-1:0];
        ram_wdata   = mem_dataintomem;
        ram_raddr   = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (cache_win) begin
                    mem_ack_d = 1'b1;
                    last_d    = WIN_CACHE;
                end else if (dma_win) begin
                    access_d = 1'b0;
                    last_d   = WIN_DMA;
                end
            end
            ST_ACK: begin
                addr_d = mem_addr[ADDR_W-1:0];
                ram_we = mem_we;
            end
            ST_RD_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_ISSUE) begin
                    ram_re    = 1'b1;
                    rd_vld_p0 = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    ram_re    = 1'b1;
                    ram_raddr = pair_full[ADDR_W-1:0];
                    rd_vld_p0 = 1'b1;
                end
            end
            // First DMA_GO cycle issues the store access, second one registers the result.
            ST_DMA_GO: begin
                if (!dma_ph_q) begin
                    dma_ph_d  = 1'b1;
                    ram_we    = dma_we;
                    ram_waddr = dma_addr[ADDR_W-1:0];
                    ram_wdata = dma_wdata;
                    ram_re    = !dma_we;
                    ram_raddr = dma_addr[ADDR_W-1:0];
                end else begin
                    dma_ack_d   = 1'b1;
                    dma_rd_load = !dma_we;
                end
            end
            ST_DMA_DONE: access_d = 1'b1;
            default: ;
        endcase
    end

    // ---- registered control and outputs ----
    always_ff @(posedge CPU_CLK) begin
        if (!RST) begin
            last_q      <= WIN_DMA;
            cnt_q       <= '0;
            dma_ph_q    <= 1'b0;
            rd_vld_p1_q <= 1'b0;
            mem_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            access_q    <= 1'b1;
            mem_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            dma_ph_q    <= dma_ph_d;
            rd_vld_p1_q <= rd_vld_p0;
            mem_ack_q   <= mem_ack_d;
            dma_ack_q   <= dma_ack_d;
            access_q    <= access_d;
            if (rd_vld_p1_q) begin
                mem_rdata_q <= ram_rdata;
            end
            if (dma_rd_load) begin
                dma_rdata_q <= ram_rdata;
            end
        end
    end

    always_ff @(posedge CPU_CLK) begin
        addr_q <= addr_d;
    end

    // Writes are gated by reset so a reset edge never disturbs the store.
    snowball_memrsp_store #(
        .ADDR_W (ADDR_W)
    ) u_store (
        .CPU_CLK (CPU_CLK),
        .we_i    (ram_we && RST),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign mem_ack         = mem_ack_q;
    assign mem_datafrommem = mem_rdata_q;
    assign dma_mcu_access  = access_q;
    assign dma_ack         = dma_ack_q;
    assign dma_rdata       = dma_rdata_q;

`ifdef SNOWBALL_MEMRSP_STATS_EN
    logic [31:0] stat_rd_q, stat_wr_q, stat_dma_q;

    always_ff @(posedge CPU_CLK) begin
        if (!RST) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_dma_q <= '0;
        end else begin
            if ((state_q == ST_ACK) && !mem_we) stat_rd_q <= stat_rd_q + 32'd1;
            if ((state_q == ST_ACK) && mem_we)  stat_wr_q <= stat_wr_q + 32'd1;
            if (dma_ack_q)                      stat_dma_q <= stat_dma_q + 32'd1;
        end
    end

    assign stat_rd  = stat_rd_q;
    assign stat_wr  = stat_wr_q;
    assign stat_dma = stat_dma_q;
`else
    // Counters compiled out; the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_snowball_mem_responder.sv
`timescale 1ns/1ps
// Directed bench for snowball_mem_responder: reset, cache write/read burst, held request,
// DMA write/read with aliasing, simultaneous requests, reset during a read burst.
module tb_snowball_mem_responder;
    import snowball_memrsp_pkg::*;

    logic        CPU_CLK;
    logic        RST;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        mem_do_act;
    logic [31:0] mem_dataintomem;
    logic        mem_ack;
    logic [31:0] mem_datafrommem;
    logic        dma_mcu_access;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ack;
    logic [31:0] dma_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    snowball_mem_responder dut (
        .CPU_CLK         (CPU_CLK),
        .RST             (RST),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_do_act      (mem_do_act),
        .mem_dataintomem (mem_dataintomem),
        .mem_ack         (mem_ack),
        .mem_datafrommem (mem_datafrommem),
        .dma_mcu_access  (dma_mcu_access),
        .dma_req         (dma_req),
        .dma_we          (dma_we),
        .dma_addr        (dma_addr),
        .dma_wdata       (dma_wdata),
        .dma_ack         (dma_ack),
        .dma_rdata       (dma_rdata)
    );

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    // Cache write from IDLE: ack next cycle, release request two cycles after ack.
    task automatic cache_write(input logic [31:0] addr, input logic [31:0] data);
        mem_addr = addr; mem_dataintomem = data; mem_we = 1'b1; mem_do_act = 1'b1;
        tick(); chk("cwr_ack", {31'd0, mem_ack}, 32'd1);
        tick(); chk("cwr_ack_pulse", {31'd0, mem_ack}, 32'd0);
        mem_do_act = 1'b0;
        tick();
    endtask

    // DMA transfer from IDLE: grant drops next cycle, ack two cycles after the drop.
    task automatic dma_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp);
        dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        tick(); chk("dma_grant_drop", {31'd0, dma_mcu_access}, 32'd0);
        tick(); chk("dma_ack_early", {31'd0, dma_ack}, 32'd0);
        tick(); chk("dma_ack", {31'd0, dma_ack}, 32'd1);
        if (!we) chk("dma_rdata", dma_rdata, exp);
        dma_req = 1'b0;
        tick(); chk("dma_regrant", {31'd0, dma_mcu_access}, 32'd1);
        chk("dma_ack_pulse", {31'd0, dma_ack}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int acks;
        int bad;
        RST = 1'b0;
        mem_do_act = 1'b1; mem_we = 1'b1; mem_addr = 32'h12; mem_dataintomem = 32'hDEADBEEF;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

        // Reset held with a pending cache write
        repeat (3) tick();
        chk("rst_mem_ack", {31'd0, mem_ack}, 32'd0);
        chk("rst_access", {31'd0, dma_mcu_access}, 32'd1);
        chk("rst_rdata", mem_datafrommem, 32'd0);
        chk("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
        RST = 1'b1;

        // First ack one cycle after release; request then held six more cycles
        tick(); chk("first_ack", {31'd0, mem_ack}, 32'd1);
        acks = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            acks += int'(mem_ack);
        end
        chk("held_single_ack", acks, 32'd1);
        chk("held_in_drop", 32'(dut.state_q), 32'(ST_DROP));
        mem_do_act = 1'b0;
        tick(); chk("drop_to_idle", 32'(dut.state_q), 32'(ST_IDLE));

        cache_write(32'h13, 32'h0000CAFE);

        // Read 0x13: critical word at T+4, pair word 0x12 at T+5
        mem_addr = 32'h13; mem_we = 1'b0; mem_do_act = 1'b1;
        tick(); chk("rd_ack", {31'd0, mem_ack}, 32'd1);
        tick(); chk("rd_ack_pulse", {31'd0, mem_ack}, 32'd0);
        tick(); mem_do_act = 1'b0;
        tick(); chk("rd_not_early", mem_datafrommem, 32'd0);
        tick(); chk("rd_w0", mem_datafrommem, 32'h0000CAFE);
        tick(); chk("rd_w1", mem_datafrommem, 32'hDEADBEEF);
        tick(); chk("rd_hold", mem_datafrommem, 32'hDEADBEEF);
        tick();

        // DMA write then read back; last winner becomes DMA
        dma_xfer(1'b1, 32'h20, 32'h11112222, 32'h0);
        dma_xfer(1'b0, 32'h20, 32'h0, 32'h11112222);

        // Simultaneous requests with last winner DMA: cache first, then DMA read of aliased 0x412
        mem_do_act = 1'b1; mem_we = 1'b1; mem_addr = 32'h21; mem_dataintomem = 32'h33334444;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h412;
        tick(); chk("both_cache_first", {31'd0, mem_ack}, 32'd1);
        chk("both_access_kept", {31'd0, dma_mcu_access}, 32'd1);
        tick(); mem_do_act = 1'b0;
        tick(); chk("both_dma_pending", {31'd0, dma_mcu_access}, 32'd1);
        dma_xfer(1'b0, 32'h412, 32'h0, 32'hDEADBEEF);
        dma_xfer(1'b0, 32'h21, 32'h0, 32'h33334444);

        // Reset during RD_WAIT aborts the burst
        mem_addr = 32'h12; mem_we = 1'b0; mem_do_act = 1'b1;
        tick(); chk("rw_ack", {31'd0, mem_ack}, 32'd1);
        tick(); RST = 1'b0;
        tick(); RST = 1'b1; mem_do_act = 1'b0;
        chk("rw_rdata_cleared", mem_datafrommem, 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_datafrommem !== 32'd0 || mem_ack !== 1'b0) bad++;
        end
        chk("rw_no_late_data", bad, 32'd0);
        chk("rw_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rw_access", {31'd0, dma_mcu_access}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
